// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t : FSM encoding (IDLE, RUN, DONE)
//   cnt_w() : bit-counter width for a given operand width (clog2, min 1)
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addsub_fa.sv
// fa_cell: combinational 1-bit full adder, the only arithmetic in the block.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial A+B+cin / A-B, one bit per clock, LSB first.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, accepted only in IDLE
//   a, b, cin, sub: operands/mode, sampled on the accepting edge
//   busy          : high in RUN
//   done          : one-cycle result-valid pulse (DONE state)
//   sum, cout, ovf: result, carry out (no-borrow for sub), signed overflow
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sr, b_sr, sum_sr;
  logic [CW-1:0]      cnt;
  logic               carry;
  logic               cout_r, ovf_r;
  logic               s, c;
  logic               last;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= a;
          // Subtraction as A + ~B + 1: invert B, force carry-in to 1.
          b_sr  <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          cnt   <= '0;
        end
        RUN: begin
          sum_sr <= {s, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c;
          cnt    <= cnt + CW'(1);
          if (last) begin
            cout_r <= c;
            // On the MSB cycle, carry still holds the carry into the MSB.
            ovf_r  <= carry ^ c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_sr;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
    int         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  // WIDTH=8 instance
  logic       start8 = 0, cin8 = 0, sub8 = 0;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic       busy8, done8, cout8, ovf8;

  // WIDTH=4 instance
  logic       start4 = 0, cin4 = 0, sub4 = 0;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic       busy4, done4, cout4, ovf4;

  exp_t q8[$];
  exp_t q4[$];

  serial_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s tag=%0d actual=0x%0h expected=0x%0h", name, tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy8 && done8) chk("busy_done_overlap8", 0, 1, 0);
      if (done8) begin
        if (q8.size() == 0) chk("unexpected_done8", cyc, 1, 0);
        else begin
          e = q8.pop_front();
          chk("sum8",  e.tag, 32'(sum8), 32'(e.sum));
          chk("cout8", e.tag, 32'(cout8), 32'(e.cout));
          chk("ovf8",  e.tag, 32'(ovf8), 32'(e.ovf));
          chk("lat8",  e.tag, 32'(cyc), 32'(e.cyc));
        end
      end
      if (busy4 && done4) chk("busy_done_overlap4", 0, 1, 0);
      if (done4) begin
        if (q4.size() == 0) chk("unexpected_done4", cyc, 1, 0);
        else begin
          e = q4.pop_front();
          chk("sum4",  e.tag, 32'(sum4), 32'(e.sum));
          chk("cout4", e.tag, 32'(cout4), 32'(e.cout));
          chk("ovf4",  e.tag, 32'(ovf4), 32'(e.ovf));
          chk("lat4",  e.tag, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic wait_done8(input int tag);
    int n = 0;
    while (!done8 && n < 40) begin tick(); n++; end
    if (!done8) chk("timeout8", tag, 1, 0);
    tick();  // DONE -> IDLE
  endtask

  task automatic run8(input int tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic sb, input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + 8; e.tag = tag;
    q8.push_back(e);
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; start8 = 1;
    tick();
    start8 = 0;
    wait_done8(tag);
  endtask

  task automatic run4(input int tag, input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic sb);
    exp_t e;
    logic [4:0] full;
    int n = 0;
    // Reference: plain integer arithmetic on the whole word.
    if (sb) full = {1'b0, a} + {1'b0, ~b} + 5'd1;
    else    full = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    e.sum  = {4'd0, full[3:0]};
    e.cout = full[4];
    if (sb) e.ovf = (a[3] != b[3]) && (full[3] != a[3]);
    else    e.ovf = (a[3] == b[3]) && (full[3] != a[3]);
    e.cyc = cyc + 1 + 4; e.tag = tag;
    q4.push_back(e);
    a4 = a; b4 = b; cin4 = ci; sub4 = sb; start4 = 1;
    tick();
    start4 = 0;
    while (!done4 && n < 20) begin tick(); n++; end
    if (!done4) chk("timeout4", tag, 1, 0);
    tick();
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       ci, sb;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;

  vec_t vecs[7] = '{
    '{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0},
    '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
    '{8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
    '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1}
  };

  initial begin
    exp_t e;
    int   n;
    int   k;
    repeat (3) tick();
    // Reset state
    chk("rst_busy8", 0, 32'(busy8), 0);
    chk("rst_done8", 0, 32'(done8), 0);
    chk("rst_sum8",  0, 32'(sum8), 0);
    chk("rst_cout8", 0, 32'(cout8), 0);
    chk("rst_ovf8",  0, 32'(ovf8), 0);
    chk("rst_busy4", 0, 32'(busy4), 0);
    rst = 0;
    tick();

    foreach (vecs[i])
      run8(i + 1, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, vecs[i].s, vecs[i].co, vecs[i].ov);

    // Start held high across two operations; operands scrambled during RUN.
    k = cyc;
    e.sum = 8'h2D; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = k + 9;  e.tag = 20; q8.push_back(e);
    e.sum = 8'h0E; e.cout = 1'b1; e.ovf = 1'b0; e.cyc = k + 19; e.tag = 21; q8.push_back(e);
    a8 = 8'h12; b8 = 8'h1B; cin8 = 0; sub8 = 0; start8 = 1;
    tick();
    chk("busy_after_accept", 20, 32'(busy8), 1);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1; sub8 = 1;
    n = 0;
    while (!done8 && n < 40) begin tick(); n++; end
    if (!done8) chk("timeout8", 20, 1, 0);
    // Second op: 0x20 - 0x12 = 0x0E, sampled on the first IDLE edge.
    a8 = 8'h20; b8 = 8'h12; cin8 = 0; sub8 = 1;
    tick();  // DONE -> IDLE, start ignored
    tick();  // accepted here
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 0;
    tick();
    start8 = 0;
    wait_done8(21);
    repeat (12) tick();  // any stray done would hit an empty queue

    // Reset three cycles into RUN: abort without done.
    a8 = 8'h33; b8 = 8'h44; cin8 = 0; sub8 = 0; start8 = 1;
    tick();
    start8 = 0;
    repeat (3) tick();
    rst = 1;
    tick();
    chk("midrst_busy", 30, 32'(busy8), 0);
    chk("midrst_done", 30, 32'(done8), 0);
    chk("midrst_sum",  30, 32'(sum8), 0);
    chk("midrst_cout", 30, 32'(cout8), 0);
    chk("midrst_ovf",  30, 32'(ovf8), 0);
    rst = 0;
    repeat (10) tick();
    run8(31, 8'h33, 8'h44, 1'b1, 1'b0, 8'h78, 1'b0, 1'b0);

    // Exhaustive WIDTH=4: add with cin 0/1, and subtract.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int m = 0; m < 3; m++)
          run4(1000 + x * 48 + y * 3 + m, 4'(x), 4'(y), m == 1, m == 2);

    repeat (3) tick();
    chk("q8_drained", 0, 32'(q8.size()), 0);
    chk("q4_drained", 0, 32'(q4.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
